// File: rtl/tour_cmd_seq.sv
// Knight's-tour command sequencer between the UART wrapper and cmd_proc.
// Optional abort of a running tour via opcode F: define TOUR_ABORT_EN.
module tour_cmd_seq #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic             clr_cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp,
  output logic             send_resp_UART
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VERT   = 3'd1;
  localparam logic [2:0] S_WAIT_V = 3'd2;
  localparam logic [2:0] S_HORZ   = 3'd3;
  localparam logic [2:0] S_WAIT_H = 3'd4;

  localparam logic [7:0] HD_N = 8'h00;
  localparam logic [7:0] HD_W = 8'h3F;
  localparam logic [7:0] HD_S = 8'h7F;
  localparam logic [7:0] HD_E = 8'hBF;

  localparam logic [7:0] RESP_MOVE = 8'h5A;
  localparam logic [7:0] RESP_DONE = 8'hA5;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [7:0]       w_vh;
  logic [3:0]       w_vs;
  logic [7:0]       w_hh;
  logic [3:0]       w_hs;
  logic [15:0]      w_vcmd;
  logic [15:0]      w_hcmd;
  logic             w_last;
  logic             w_abort;

  assign mv_indx = r_idx;
  assign w_last  = (r_idx == IDX_W'(NUM_MOVES - 1));
  assign w_vcmd  = {4'h4, w_vh, w_vs};
  assign w_hcmd  = {4'h5, w_hh, w_hs};

`ifdef TOUR_ABORT_EN
  assign w_abort = cmd_rdy_UART && (cmd_UART[15:12] == 4'hF);
`else
  assign w_abort = 1'b0;
`endif

  // Lowest set bit selects the move when the solver word is multi-hot.
  always_comb begin
    w_vh = HD_N;
    w_vs = 4'd2;
    w_hh = HD_W;
    w_hs = 4'd1;
    priority casez (move)
      8'b???????1: begin
        w_vh = HD_N; w_vs = 4'd2;
        w_hh = HD_W; w_hs = 4'd1;
      end
      8'b??????10: begin
        w_vh = HD_N; w_vs = 4'd2;
        w_hh = HD_E; w_hs = 4'd1;
      end
      8'b?????100: begin
        w_vh = HD_N; w_vs = 4'd1;
        w_hh = HD_W; w_hs = 4'd2;
      end
      8'b????1000: begin
        w_vh = HD_S; w_vs = 4'd1;
        w_hh = HD_W; w_hs = 4'd2;
      end
      8'b???10000: begin
        w_vh = HD_S; w_vs = 4'd2;
        w_hh = HD_W; w_hs = 4'd1;
      end
      8'b??100000: begin
        w_vh = HD_S; w_vs = 4'd2;
        w_hh = HD_E; w_hs = 4'd1;
      end
      8'b?1000000: begin
        w_vh = HD_S; w_vs = 4'd1;
        w_hh = HD_E; w_hs = 4'd2;
      end
      8'b10000000: begin
        w_vh = HD_N; w_vs = 4'd1;
        w_hh = HD_E; w_hs = 4'd2;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_nxt            = r_state;
    w_idx_nxt        = r_idx;
    cmd              = w_vcmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_MOVE;
    send_resp_UART   = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        send_resp_UART   = send_resp;
        if (start_tour) begin
          w_nxt     = S_VERT;
          w_idx_nxt = '0;
        end
      end
      S_VERT: begin
        if (move == 8'h00) begin
          resp           = RESP_DONE;
          send_resp_UART = 1'b1;
          w_nxt          = S_IDLE;
          w_idx_nxt      = '0;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) w_nxt = S_WAIT_V;
        end
      end
      S_WAIT_V: begin
        if (send_resp) w_nxt = S_HORZ;
      end
      S_HORZ: begin
        cmd     = w_hcmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) w_nxt = S_WAIT_H;
      end
      S_WAIT_H: begin
        cmd = w_hcmd;
        if (send_resp) begin
          send_resp_UART = 1'b1;
          if (w_last) begin
            resp      = RESP_DONE;
            w_nxt     = S_IDLE;
            w_idx_nxt = '0;
          end else begin
            w_nxt     = S_VERT;
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_nxt     = S_IDLE;
        w_idx_nxt = '0;
      end
    endcase
    // Abort wins over any tour-state action; no new leg is offered.
    if (r_state != S_IDLE && w_abort) begin
      clr_cmd_rdy_UART = 1'b1;
      send_resp_UART   = 1'b1;
      resp             = RESP_DONE;
      cmd_rdy          = 1'b0;
      w_nxt            = S_IDLE;
      w_idx_nxt        = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

endmodule
